scsp_midi_tx: RTL and testbench
===============================

Name: scsp_midi_tx

Overview:
- Serial end of the SCSP MIDI output path.
- Accepts bytes the sound CPU writes to the MOBUF field (CR3, 100406) and buffers them in a small FIFO.
- Serialises each byte as an 8N1 MIDI frame on MIDI_OUT.
- Supplies the CR2 output status bits OE (FIFO empty) and OF (FIFO full) back to the register block.

Parameters:
- CLK_DIV, 722: CE cycles per serial bit. 22.5792 MHz / 31250 baud ≈ 722. Legal range 2..4095.
- FIFO_DEPTH, 4: MIDI output FIFO entries. Must be a power of two, 2..16.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous reset, active-high
- CE  in  1  clock enable; baud counter and serialiser advance only when CE=1
- MOBUF_DATA  in  8  byte written to MOBUF
- MOBUF_WE  in  1  one-CLK write strobe for MOBUF_DATA; independent of CE
- OE  out  1  FIFO empty (CR2.OE)
- OF  out  1  FIFO full (CR2.OF)
- FIFO_CNT  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- BUSY  out  1  serialiser not IDLE
- MIDI_OUT  out  1  serial line; idle/mark = 1

Behaviour:
- Reset (RST=1 at a CLK edge, dominant over all other inputs):
  - FIFO pointers and count cleared; OE=1, OF=0, FIFO_CNT=0.
  - State=IDLE, baud counter=0, BUSY=0, MIDI_OUT=1.
  - Reset mid-frame aborts the frame immediately; MIDI_OUT returns to 1 on the next cycle.
- FIFO:
  - Write on MOBUF_WE=1 when not full; data is visible (OE=0) the next CLK.
  - Write while full is silently dropped; contents are unchanged.
  - Pop happens only on the serialiser load cycle.
  - Write and pop in the same CLK: both take effect and count is unchanged. This holds when full: the write is accepted because the pop frees a slot.
  - Pointers wrap modulo FIFO_DEPTH.
  - OE = (count==0) and OF = (count==FIFO_DEPTH), both registered from the count.
- Baud counter:
  - Counts CE cycles 0..CLK_DIV-1; bit_end = CE && cnt==CLK_DIV-1.
  - Cleared on every state load.
- State machine (transitions only on CE=1):
  - IDLE: if FIFO not empty → pop the head into shift register, MIDI_OUT=0, go to START, cnt=0.
  - START: MIDI_OUT=0; on bit_end → DATA, bit index=0, MIDI_OUT=shift[0].
  - DATA: LSB first; on bit_end, if index<7 → index+1 and output the next bit; if index==7 → STOP, MIDI_OUT=1.
  - STOP: MIDI_OUT=1; on bit_end:
    - FIFO not empty → pop and go directly to START with no idle gap.
    - FIFO empty → IDLE.
- Timing:
  - Frame length is exactly 10*CLK_DIV CE cycles.
  - Latency from the write strobe to the falling start edge is 2 CLK at CE=1: one cycle for the FIFO write, one for the load.
- BUSY = (state != IDLE). MIDI_OUT is registered.
- CE=0 freezes the counter and state; FIFO writes still proceed.

Optional Feature:
- Macro: SCSP_MIDI_TX_OVR_EN.
- Defined:
  - Adds output OVR (1 bit) and input OVR_CLR (1 bit).
  - OVR sets on a dropped write (MOBUF_WE while full with no simultaneous pop). It is sticky.
  - OVR clears on OVR_CLR=1 or RST. Set wins over a simultaneous clear.
  - Reset value 0.
- Not defined: ports absent; dropped writes leave no trace.

Test Plan (CLK_DIV=4, FIFO_DEPTH=4, CE=1 unless stated):
- Single byte: write 0x90 → MIDI_OUT shows start bit, then 0,0,0,0,1,0,0,1, then stop; each bit 4 CLK; BUSY falls 40 CLK after load; OE 1→0→1.
- Back-to-back: write 0x90,0x3C,0x7F in consecutive CLKs → three contiguous 40-CLK frames, no idle cycles between stop and the next start; FIFO_CNT peaks at 2.
- Full/drop: with CE=0, write 0x01..0x05 → OF=1 after the 4th write; 5th dropped (OVR=1 if enabled); with CE=1, bytes 0x01..0x04 are emitted and 0x05 never appears.
- Write-while-full with pop: fill 4 entries, then write 0xAA in the load cycle → accepted, count stays 4, and 0xAA is transmitted last.
- CE gating: CE toggles 1/0 each CLK → each bit lasts 8 CLK, and a write during CE=0 is still captured.
- Reset mid-frame: assert RST during data bit 3 of 0x55 → next CLK MIDI_OUT=1, OE=1, BUSY=0, and no residual frame after release.

Source files
------------

// File: rtl/scsp_midi_tx_if.sv
// scsp_midi_tx_if: MOBUF write port and CR2 FIFO status between the register block and the MIDI transmitter
interface scsp_midi_tx_if #(
    parameter int FIFO_DEPTH = 4
);
    logic [7:0]                    MOBUF_DATA;
    logic                          MOBUF_WE;
    logic                          OE;
    logic                          OF;
    logic [$clog2(FIFO_DEPTH):0]   FIFO_CNT;
    modport master (output MOBUF_DATA, MOBUF_WE, input OE, OF, FIFO_CNT);
    modport slave  (input MOBUF_DATA, MOBUF_WE, output OE, OF, FIFO_CNT);
endinterface

// File: rtl/scsp_midi_tx.sv
// scsp_midi_tx: MOBUF FIFO feeding an 8N1 MIDI serialiser; define SCSP_MIDI_TX_OVR_EN to add the sticky OVR flag with OVR_CLR
module scsp_midi_tx #(
    parameter int CLK_DIV    = 722,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          CE,
    scsp_midi_tx_if.slave bus,
`ifdef SCSP_MIDI_TX_OVR_EN
    input  logic          OVR_CLR,
    output logic          OVR,
`endif
    output logic          BUSY,
    output logic          MIDI_OUT
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t        state_q, state_d;
    logic [11:0]   cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          out_q, out_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic          oe_q, oe_d, of_q, of_d;
    logic          empty, full, bit_end, pop, push;

    assign empty   = count_q == '0;
    assign full    = count_q == CW'(FIFO_DEPTH);
    assign bit_end = CE && cnt_q == 12'(CLK_DIV - 1);

    // Serialiser: a load (pop) restarts the frame from IDLE or straight out of STOP; otherwise bit_end steps the frame
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        out_d   = out_q;
        cnt_d   = (CE && state_q != IDLE) ? (bit_end ? '0 : cnt_q + 12'd1) : cnt_q;
        pop     = CE && !empty && (state_q == IDLE || (state_q == STOP && bit_end));
        if (pop) begin
            state_d = START;
            shift_d = mem_q[rd_q];
            out_d   = 1'b0;
            cnt_d   = '0;
        end else if (bit_end) begin
            case (state_q)
                START: begin
                    state_d = DATA;
                    idx_d   = 3'd0;
                    out_d   = shift_q[0];
                end
                DATA: begin
                    state_d = (idx_q == 3'd7) ? STOP : DATA;
                    idx_d   = idx_q + 3'd1;
                    out_d   = (idx_q == 3'd7) ? 1'b1 : shift_q[idx_q + 3'd1];
                end
                STOP:    state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    // FIFO: a write is taken when there is room, counting the slot freed by a same-cycle pop
    always_comb begin
        push    = bus.MOBUF_WE && (!full || pop);
        mem_d   = mem_q;
        if (push) mem_d[wr_q] = bus.MOBUF_DATA;
        wr_d    = push ? wr_q + AW'(1) : wr_q;
        rd_d    = pop ? rd_q + AW'(1) : rd_q;
        count_d = count_q + CW'(push) - CW'(pop);
        oe_d    = count_d == '0;
        of_d    = count_d == CW'(FIFO_DEPTH);
    end

    // Control state and status flags, all cleared by reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            out_q   <= 1'b1;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            oe_q    <= 1'b1;
            of_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            out_q   <= out_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            oe_q    <= oe_d;
            of_q    <= of_d;
        end
    end

    // FIFO storage needs no reset: the count decides which entries are valid
    always_ff @(posedge CLK) mem_q <= mem_d;

`ifdef SCSP_MIDI_TX_OVR_EN
    logic ovr_q, ovr_d;
    // Sticky overrun: a dropped write sets it and beats a simultaneous clear
    always_comb ovr_d = (bus.MOBUF_WE && full && !pop) ? 1'b1 : OVR_CLR ? 1'b0 : ovr_q;
    // Overrun register
    always_ff @(posedge CLK) ovr_q <= RST ? 1'b0 : ovr_d;
    assign OVR = ovr_q;
`endif

    assign bus.OE       = oe_q;
    assign bus.OF       = of_q;
    assign bus.FIFO_CNT = count_q;
    assign BUSY         = state_q != IDLE;
    assign MIDI_OUT     = out_q;
endmodule

// File: tb/tb_scsp_midi_tx.sv
// tb_scsp_midi_tx: randomized bench checking scsp_midi_tx against a frame-level line model and a UART-style decoder
module tb_scsp_midi_tx;
    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 4;
    typedef logic bitq_t[$];
    typedef logic [7:0] byteq_t[$];

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic CE  = 1'b1;
    logic BUSY, MIDI_OUT;
`ifdef SCSP_MIDI_TX_OVR_EN
    logic OVR_CLR = 1'b0;
    logic OVR;
`endif
    int    pass_cnt = 0;
    int    total    = 0;
    bit    ce_tog   = 1'b0;
    bit    rec      = 1'b0;
    bitq_t line;
    bitq_t busy_l;
    bitq_t oe_l;
    int    max_cnt  = 0;

    scsp_midi_tx_if #(.FIFO_DEPTH(DEPTH)) bus ();

    scsp_midi_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .CE(CE), .bus(bus),
`ifdef SCSP_MIDI_TX_OVR_EN
        .OVR_CLR(OVR_CLR), .OVR(OVR),
`endif
        .BUSY(BUSY), .MIDI_OUT(MIDI_OUT)
    );

    always #5 CLK = ~CLK;

    // Line recorder: one sample per cycle, taken on the falling edge
    always @(negedge CLK) begin
        if (rec) begin
            line.push_back(MIDI_OUT);
            busy_l.push_back(BUSY);
            oe_l.push_back(bus.OE);
            if (int'(bus.FIFO_CNT) > max_cnt) max_cnt = int'(bus.FIFO_CNT);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Ideal line for a run of frames: start 0, data LSB first, stop 1, each bit bl samples
    function automatic bitq_t frames(byteq_t bs, int bl);
        bitq_t r;
        foreach (bs[i])
            for (int b = 0; b < 10; b++)
                repeat (bl) r.push_back(b == 0 ? 1'b0 : b == 9 ? 1'b1 : bs[i][b-1]);
        return r;
    endfunction

    function automatic logic at(bitq_t q, int i);
        return (i >= 0 && i < q.size()) ? q[i] : 1'bx;
    endfunction

    function automatic int first_zero();
        foreach (line[i]) if (line[i] === 1'b0) return i;
        return -1;
    endfunction

    // Samples differing from the model line starting at s, with the line idle (1) afterwards
    function automatic int stream_diff(bitq_t exp, int s);
        int n = 0;
        foreach (exp[k]) if (at(line, s + k) !== exp[k]) n++;
        for (int k = s + exp.size(); k < line.size(); k++) if (line[k] !== 1'b1) n++;
        return n;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
        if (ce_tog) CE = ~CE;
    endtask

    task automatic write(input logic [7:0] b);
        bus.MOBUF_DATA = b;
        bus.MOBUF_WE   = 1'b1;
        tick();
        bus.MOBUF_WE   = 1'b0;
    endtask

    task automatic start_rec();
        line.delete();
        busy_l.delete();
        oe_l.delete();
        max_cnt = 0;
        rec = 1'b1;
    endtask

    task automatic stop_rec();
        rec = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 600; i++) begin
            if (!BUSY && bus.OE) return;
            tick();
        end
        total++;
        $display("FAIL idle_timeout busy=%b oe=%b exp busy=0 oe=1", BUSY, bus.OE);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        CE  = 1'b1;
        repeat (3) tick();
        total++; if (bus.OE !== 1'b1) $display("FAIL reset_oe got %b exp 1", bus.OE); else pass_cnt++;
        total++; if (bus.OF !== 1'b0) $display("FAIL reset_of got %b exp 0", bus.OF); else pass_cnt++;
        total++; if (bus.FIFO_CNT !== 3'd0) $display("FAIL reset_cnt got %0d exp 0", bus.FIFO_CNT); else pass_cnt++;
        total++; if (BUSY !== 1'b0) $display("FAIL reset_busy got %b exp 0", BUSY); else pass_cnt++;
        total++; if (MIDI_OUT !== 1'b1) $display("FAIL reset_line got %b exp 1", MIDI_OUT); else pass_cnt++;
        RST = 1'b0;
        tick();
    endtask

    task automatic test_single(input logic [7:0] b);
        int s, bad;
        byteq_t m;
        m.push_back(b);
        CE = 1'b1;
        start_rec();
        write(b);
        total++; if (bus.OE !== 1'b0 || bus.FIFO_CNT !== 3'd1) $display("FAIL single_write oe=%b cnt=%0d exp oe=0 cnt=1", bus.OE, bus.FIFO_CNT); else pass_cnt++;
        repeat (50) tick();
        stop_rec();
        s = first_zero();
        total++; if (s != 2) $display("FAIL single_latency got %0d exp 2", s); else pass_cnt++;
        bad = stream_diff(frames(m, CLK_DIV), s);
        total++; if (bad != 0) $display("FAIL single_frame byte=%h bad_samples=%0d exp 0", b, bad); else pass_cnt++;
        total++; if (at(oe_l, s - 1) !== 1'b0 || at(oe_l, s) !== 1'b1) $display("FAIL single_oe got %b%b exp 01", at(oe_l, s - 1), at(oe_l, s)); else pass_cnt++;
        total++; if (at(busy_l, s + 39) !== 1'b1 || at(busy_l, s + 40) !== 1'b0) $display("FAIL single_busy got %b%b exp 10", at(busy_l, s + 39), at(busy_l, s + 40)); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int s, bad;
        byteq_t m;
        m = '{8'h90, 8'h3C, 8'h7F};
        CE = 1'b1;
        start_rec();
        foreach (m[i]) write(m[i]);
        repeat (130) tick();
        stop_rec();
        s = first_zero();
        total++; if (s != 2) $display("FAIL b2b_latency got %0d exp 2", s); else pass_cnt++;
        bad = stream_diff(frames(m, CLK_DIV), s);
        total++; if (bad != 0) $display("FAIL b2b_stream bad_samples=%0d exp 0", bad); else pass_cnt++;
        total++; if (max_cnt != 2) $display("FAIL b2b_peak got %0d exp 2", max_cnt); else pass_cnt++;
    endtask

    task automatic test_full_drop();
        int s, bad;
        byteq_t m;
        CE = 1'b0;
        start_rec();
        for (int i = 1; i <= 5; i++) begin
            write(8'(i));
            if (m.size() < DEPTH) m.push_back(8'(i));
            if (i == 3) begin
                total++; if (bus.OF !== 1'b0) $display("FAIL drop_of3 got %b exp 0", bus.OF); else pass_cnt++;
            end
            if (i == 4) begin
                total++; if (bus.OF !== 1'b1 || bus.FIFO_CNT !== 3'd4) $display("FAIL drop_full of=%b cnt=%0d exp of=1 cnt=4", bus.OF, bus.FIFO_CNT); else pass_cnt++;
            end
        end
        total++; if (bus.FIFO_CNT !== 3'd4 || bus.OF !== 1'b1) $display("FAIL drop_after cnt=%0d of=%b exp cnt=4 of=1", bus.FIFO_CNT, bus.OF); else pass_cnt++;
`ifdef SCSP_MIDI_TX_OVR_EN
        total++; if (OVR !== 1'b1) $display("FAIL drop_ovr got %b exp 1", OVR); else pass_cnt++;
        OVR_CLR = 1'b1;
        tick();
        OVR_CLR = 1'b0;
        total++; if (OVR !== 1'b0) $display("FAIL drop_ovr_clr got %b exp 0", OVR); else pass_cnt++;
`endif
        CE = 1'b1;
        repeat (180) tick();
        stop_rec();
        s = first_zero();
        bad = stream_diff(frames(m, CLK_DIV), s);
        total++; if (s < 0 || bad != 0) $display("FAIL drop_stream start=%0d bad_samples=%0d exp 0", s, bad); else pass_cnt++;
    endtask

    task automatic test_full_pop();
        int s, bad;
        logic [7:0] b;
        byteq_t m;
        CE = 1'b0;
        start_rec();
        repeat (DEPTH) begin
            b = 8'($urandom);
            write(b);
            m.push_back(b);
        end
        total++; if (bus.OF !== 1'b1) $display("FAIL fpop_full got %b exp 1", bus.OF); else pass_cnt++;
        CE = 1'b1;
        write(8'hAA);
        m.push_back(8'hAA);
        total++; if (bus.FIFO_CNT !== 3'd4 || bus.OF !== 1'b1) $display("FAIL fpop_cnt cnt=%0d of=%b exp cnt=4 of=1", bus.FIFO_CNT, bus.OF); else pass_cnt++;
        repeat (220) tick();
        stop_rec();
        s = first_zero();
        bad = stream_diff(frames(m, CLK_DIV), s);
        total++; if (s < 0 || bad != 0) $display("FAIL fpop_stream start=%0d bad_samples=%0d exp 0", s, bad); else pass_cnt++;
    endtask

    task automatic test_ce_gating();
        int s, bad;
        byteq_t m;
        m.push_back(8'($urandom));
        CE = 1'b1;
        ce_tog = 1'b1;
        start_rec();
        if (CE) tick();
        write(m[0]);
        total++; if (bus.FIFO_CNT !== 3'd1) $display("FAIL ce_capture cnt=%0d exp 1", bus.FIFO_CNT); else pass_cnt++;
        repeat (100) tick();
        stop_rec();
        ce_tog = 1'b0;
        CE = 1'b1;
        s = first_zero();
        bad = stream_diff(frames(m, 2 * CLK_DIV), s);
        total++; if (s < 0 || bad != 0) $display("FAIL ce_stream byte=%h start=%0d bad_samples=%0d exp 0", m[0], s, bad); else pass_cnt++;
    endtask

    task automatic test_random();
        int i, framing;
        logic [7:0] v;
        byteq_t m, got;
        CE = 1'b1;
        start_rec();
        repeat (5) begin
            repeat ($urandom_range(0, 50)) tick();
            v = 8'($urandom);
            write(v);
            m.push_back(v);
        end
        repeat (220) tick();
        stop_rec();
        i = 0;
        framing = 0;
        while (i < line.size()) begin
            if (line[i] === 1'b0) begin
                for (int k = 0; k < 8; k++) v[k] = at(line, i + (k + 1) * CLK_DIV + CLK_DIV / 2);
                got.push_back(v);
                if (at(line, i + 9 * CLK_DIV + CLK_DIV / 2) !== 1'b1) framing++;
                i += 10 * CLK_DIV;
            end else i++;
        end
        total++; if (got.size() != m.size()) $display("FAIL rand_count got %0d exp %0d", got.size(), m.size()); else pass_cnt++;
        total++; if (framing != 0) $display("FAIL rand_stop bad_stops=%0d exp 0", framing); else pass_cnt++;
        for (int k = 0; k < m.size() && k < got.size(); k++) begin
            total++; if (got[k] !== m[k]) $display("FAIL rand_byte%0d got %h exp %h", k, got[k], m[k]); else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        int busy_cnt;
        CE = 1'b1;
        write(8'h55);
        write(8'($urandom));
        repeat (16) tick();
        total++; if (MIDI_OUT !== 1'b0 || BUSY !== 1'b1) $display("FAIL mid_bit3 line=%b busy=%b exp line=0 busy=1", MIDI_OUT, BUSY); else pass_cnt++;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        total++; if (MIDI_OUT !== 1'b1) $display("FAIL mid_line got %b exp 1", MIDI_OUT); else pass_cnt++;
        total++; if (bus.OE !== 1'b1 || bus.FIFO_CNT !== 3'd0) $display("FAIL mid_fifo oe=%b cnt=%0d exp oe=1 cnt=0", bus.OE, bus.FIFO_CNT); else pass_cnt++;
        total++; if (BUSY !== 1'b0) $display("FAIL mid_busy got %b exp 0", BUSY); else pass_cnt++;
        start_rec();
        repeat (60) tick();
        stop_rec();
        busy_cnt = 0;
        foreach (busy_l[k]) if (busy_l[k] !== 1'b0) busy_cnt++;
        total++; if (first_zero() != -1 || busy_cnt != 0) $display("FAIL mid_residual zero_at=%0d busy_samples=%0d exp -1 and 0", first_zero(), busy_cnt); else pass_cnt++;
    endtask

    initial begin
        bus.MOBUF_DATA = 8'h00;
        bus.MOBUF_WE   = 1'b0;
        test_reset();
        test_single(8'h90);
        wait_idle();
        test_single(8'($urandom));
        wait_idle();
        test_single(8'($urandom));
        wait_idle();
        test_back_to_back();
        wait_idle();
        test_full_drop();
        wait_idle();
        test_full_pop();
        wait_idle();
        test_ce_gating();
        wait_idle();
        test_random();
        wait_idle();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
